// File: rtl/oled_fb_scanout_pkg.sv
// Shared OLED definitions: SSD1306 addressing commands, scan-out state
// encoding and the default panel geometry.
package oled_fb_scanout_pkg;

  localparam logic [7:0] CMD_SET_COL_ADDR  = 8'h21;
  localparam logic [7:0] CMD_SET_PAGE_ADDR = 8'h22;

  localparam int DEF_COLS  = 128;
  localparam int DEF_PAGES = 8;

  // Number of bytes in the window-setup preamble sent before pixel data.
  localparam int NUM_CMD_BYTES = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_FIN
  } scan_state_t;

  // Preamble byte i: full-window column range, then full-window page range.
  function automatic logic [7:0] cmd_byte(input logic [2:0] i,
                                          input int cols,
                                          input int pages);
    case (i)
      3'd0:    return CMD_SET_COL_ADDR;
      3'd1:    return 8'h00;
      3'd2:    return 8'(cols - 1);
      3'd3:    return CMD_SET_PAGE_ADDR;
      3'd4:    return 8'h00;
      default: return 8'(pages - 1);
    endcase
  endfunction

endpackage

// File: rtl/oled_fb_ram.sv
// Dual-port framebuffer RAM, registered reads on both ports.
module oled_fb_ram #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Writes from either port (A wins on a collision) and 1-cycle reads.
  // NOTE: the array has no reset; clearing a RAM prevents block-RAM mapping.
  always_ff @(posedge clk) begin
    if (we_a)      mem[addr_a] <= wdata_a;
    else if (we_b) mem[addr_b] <= wdata_b;
    rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
  end

endmodule

// File: rtl/oled_fb_scanout.sv
// Frame scan-out: sends the SSD1306 window preamble, then streams every
// framebuffer byte of the selected half, page-major, to the serial driver.
module oled_fb_scanout
  import oled_fb_scanout_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int COLS       = DEF_COLS,
  parameter int PAGES      = DEF_PAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  buf_sel,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  input  logic [DATA_WIDTH-1:0] fb_rdata,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_byte,
  output logic                  tx_dc
);

  localparam int IDX_W = ADDR_WIDTH - 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COLS * PAGES - 1);

  scan_state_t           state_q, state_d;
  logic [2:0]            cmd_cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  buf_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  accept;

  assign accept = tx_valid && tx_ready;

  // State register plus counters, address and holding register.
  // NOTE: clocked state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_cnt_q <= '0;
      idx_q     <= '0;
      buf_q     <= 1'b0;
      hold_q    <= '0;
      fb_addr   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (start) begin
          buf_q     <= buf_sel;
          cmd_cnt_q <= '0;
          idx_q     <= '0;
        end
        S_CMD: if (accept) begin
          cmd_cnt_q <= cmd_cnt_q + 3'd1;
          if (cmd_cnt_q == 3'(NUM_CMD_BYTES - 1)) fb_addr <= {buf_q, idx_q};
        end
        S_WAIT: hold_q <= fb_rdata;
        S_SEND: if (accept && idx_q != IDX_LAST) begin
          // idx stops at IDX_LAST, so the address never crosses halves.
          idx_q   <= idx_q + 1'b1;
          fb_addr <= {buf_q, idx_q + 1'b1};
        end
        default: ;
      endcase
    end
  end

  // Next-state and Moore outputs; tx_valid never looks at tx_ready.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    done     = 1'b0;
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    tx_dc    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_CMD;
      S_CMD: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_byte  = cmd_byte(cmd_cnt_q, COLS, PAGES);
        if (tx_ready && cmd_cnt_q == 3'(NUM_CMD_BYTES - 1)) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy    = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_dc    = 1'b1;
        tx_byte  = 8'(hold_q);
        if (tx_ready) state_d = (idx_q == IDX_LAST) ? S_FIN : S_FETCH;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A reset cycle must not hand over a byte the frame is about to abandon.
    if (rst) tx_valid = 1'b0;
  end

endmodule

// File: tb/tb_oled_fb_scanout.sv
// Scoreboard bench for oled_fb_scanout driving a real framebuffer RAM.
module tb_oled_fb_scanout;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int NDATA = 1024;

  logic          clk = 1'b0;
  logic          rst, start, buf_sel, busy, done, tx_valid, tx_ready, tx_dc;
  logic [AW-1:0] fb_addr, ram_addr_a;
  logic [DW-1:0] fb_rdata, ram_wdata_a, ram_rdata_a;
  logic [7:0]    tx_byte;
  logic          ram_we_a;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] sb_q[$];
  int         data_n, xfers, done_cnt, done_t;
  logic       cur_buf;
  bit         rnd_ready;

  always #5 clk = ~clk;

  oled_fb_scanout dut (
    .clk(clk), .rst(rst), .start(start), .buf_sel(buf_sel),
    .busy(busy), .done(done), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte), .tx_dc(tx_dc)
  );

  oled_fb_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_ram (
    .clk(clk),
    .we_a(ram_we_a), .addr_a(ram_addr_a), .wdata_a(ram_wdata_a), .rdata_a(ram_rdata_a),
    .we_b(1'b0), .addr_b(fb_addr), .wdata_b('0), .rdata_b(fb_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, sample 1 ns later, and
  // score any byte that will transfer on the coming rising edge.
  task automatic step(input logic r, input logic s, input logic b);
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    rst      = r;
    start    = s;
    buf_sel  = b;
    tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (tx_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_byte", {23'd0, tx_dc, tx_byte}, 32'h1ff);
      end else begin
        check(tx_dc ? "data_byte" : "cmd_byte", {23'd0, tx_dc, tx_byte}, {23'd0, sb_q[0]});
        if (tx_dc) begin
          exp_addr = {cur_buf, 10'(data_n)};
          check("fb_addr", {21'd0, fb_addr}, {21'd0, exp_addr});
        end
        if (tx_ready) begin
          void'(sb_q.pop_front());
          xfers++;
          if (tx_dc) data_n++;
        end
      end
    end
    if (done) done_cnt++;
  endtask

  task automatic push_frame(input logic b);
    sb_q.delete();
    sb_q.push_back(9'h021); sb_q.push_back(9'h000); sb_q.push_back(9'h07f);
    sb_q.push_back(9'h022); sb_q.push_back(9'h000); sb_q.push_back(9'h007);
    for (int i = 0; i < NDATA; i++)
      sb_q.push_back(b ? 9'h1a5 : {1'b1, 8'(i)});
  endtask

  // Run one frame; restart_at/rst_at are data-byte counts (-1 = never).
  task automatic run_frame(input logic b, input int restart_at, input int rst_at,
                           input bit check_len);
    bit restarted = 0;
    bit finished  = 0;
    push_frame(b);
    cur_buf  = b;
    data_n   = 0;
    xfers    = 0;
    done_cnt = 0;
    done_t   = -1;
    step(0, 1, b);
    for (int t = 0; t < 12000; t++) begin
      if (rst_at >= 0 && data_n == rst_at) begin
        step(1, 0, b);
        step(0, 0, b);
        check("rst_valid", {31'd0, tx_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        for (int k = 0; k < 5; k++) step(0, 0, b);
        check("rst_no_done", done_cnt, 0);
        sb_q.delete();
        finished = 1;
        break;
      end
      if (restart_at >= 0 && !restarted && data_n == restart_at) begin
        restarted = 1;
        step(0, 1, ~b);
      end else begin
        step(0, 0, b);
      end
      if (t == 0) check("busy_first_cmd", {31'd0, busy}, 1);
      if (done) begin
        done_t = t;
        check("busy_at_done", {31'd0, busy}, 0);
        finished = 1;
        break;
      end
    end
    if (!finished) check("frame_timeout", 0, 1);
    if (rst_at < 0) begin
      for (int k = 0; k < 4; k++) step(0, 0, b);
      check("done_count", done_cnt, 1);
      check("xfer_count", xfers, 6 + NDATA);
      check("sb_empty", sb_q.size(), 0);
      if (check_len) check("frame_len", done_t, 6 + 3 * NDATA);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; buf_sel = 1'b0; tx_ready = 1'b1;
    rnd_ready = 0;
    ram_we_a = 1'b0; ram_addr_a = '0; ram_wdata_a = '0;

    // Preload: lower half byte = addr[7:0], upper half 0xA5.
    for (int a = 0; a < 2 * NDATA; a++) begin
      @(negedge clk);
      ram_we_a    = 1'b1;
      ram_addr_a  = AW'(a);
      ram_wdata_a = (a < NDATA) ? 8'(a) : 8'hA5;
    end
    @(negedge clk);
    ram_we_a = 1'b0;

    step(1, 0, 0);
    step(1, 0, 0);
    check("rst_busy0", {31'd0, busy}, 0);
    check("rst_done0", {31'd0, done}, 0);
    check("rst_valid0", {31'd0, tx_valid}, 0);
    check("rst_byte0", {24'd0, tx_byte}, 0);
    check("rst_dc0", {31'd0, tx_dc}, 0);
    check("rst_addr0", {21'd0, fb_addr}, 0);

    run_frame(0, -1, -1, 1);      // lower half, ready high
    run_frame(1, -1, -1, 1);      // upper half
    rnd_ready = 1;
    run_frame(0, -1, -1, 0);      // back-pressure
    rnd_ready = 0;
    run_frame(0, 100, -1, 1);     // start while busy
    run_frame(0, -1, 500, 0);     // reset mid-frame
    run_frame(0, -1, -1, 1);      // recovery frame

    // start together with rst must be ignored.
    step(1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0);
      check("start_in_rst_busy", {31'd0, busy}, 0);
      check("start_in_rst_valid", {31'd0, tx_valid}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
